// File: rtl/jk_register_counter.sv
// jk_register_counter: JK register / up-down counter / loadable register, macro JK_COUNTER_SATURATE_EN makes counters saturate
module jk_register_counter #(
   parameter int WIDTH = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_inverse,
   output logic             tc,
   output logic             wrap
);
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] q_inc;
   logic [WIDTH-1:0] q_dec;
   assign q_inverse = ~q;
   assign tc = (mode == 2'b01 && &q) || (mode == 2'b10 && ~|q);
`ifdef JK_COUNTER_SATURATE_EN
   assign q_inc = tc ? q : q + 1'b1;
   assign q_dec = tc ? q : q - 1'b1;
`else
   assign q_inc = q + 1'b1;
   assign q_dec = q - 1'b1;
`endif
   // next state: per-bit JK table (unknown j/k falls to hold), count, or load
   always_comb begin
      q_next = q;
      case (mode)
         2'b00:
            for (int i = 0; i < WIDTH; i++)
               case ({j[i], k[i]})
                  2'b01:   q_next[i] = 1'b0;
                  2'b10:   q_next[i] = 1'b1;
                  2'b11:   q_next[i] = ~q[i];
                  default: q_next[i] = q[i];
               endcase
         2'b01:   q_next = q_inc;
         2'b10:   q_next = q_dec;
         default: q_next = load_val;
      endcase
   end
   // state register and one-cycle wrap pulse on enabled terminal-count edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q    <= RESET_VALUE;
         wrap <= 1'b0;
      end else begin
         q    <= en ? q_next : q;
         wrap <= en & tc;
      end
   end
endmodule
